// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with one outstanding imem read, decode handshake and flush/kill.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets set a sticky flag and park fetch.
`default_nettype none

module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_rvalid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  input  logic            id_ready,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] ImmOp,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            misalign
);

  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_REQ   = 2'd1;
  localparam logic [1:0]      c_WAIT  = 2'd2;
  localparam logic [1:0]      c_VALID = 2'd3;
  localparam logic [XLEN-1:0] c_STEP  = XLEN'(4);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_kill;
  logic            w_kill_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic            r_instr_valid;

  logic            w_flush;
  logic            w_consume;
  logic            w_accept;
  logic            w_redirect;
  logic            w_trap;
  logic            w_parked;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;

  assign w_flush   = flush && (r_state != c_IDLE);
  assign w_consume = (r_state == c_VALID) && id_ready && !w_flush;
  assign w_accept  = (r_state == c_WAIT) && imem_rvalid && !w_flush;

  // Redirect target: flush beats the decoder's branch/jump request.
  always_comb begin
    w_target   = r_pc;
    w_redirect = 1'b0;
    if (w_flush) begin
      w_target   = flush_pc;
      w_redirect = 1'b1;
    end else if (w_consume) begin
      case (PCSrc)
        2'b01: begin
          w_target   = r_pc_out + ImmOp;
          w_redirect = 1'b1;
        end
        2'b10: begin
          w_target   = ImmOp;
          w_redirect = 1'b1;
        end
        default: w_target = r_pc;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_trap    = w_redirect && (w_target[1:0] != 2'b00);
  assign w_next_pc = w_target;
  assign w_parked  = r_misalign;
  assign misalign  = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_trap) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_trap    = 1'b0;
  assign w_parked  = 1'b0;
  assign w_next_pc = w_redirect ? {w_target[XLEN-1:2], 2'b00} : w_target;
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    case (r_state)
      c_IDLE: begin
        if (!w_parked) w_state_nxt = c_REQ;
      end
      c_REQ: begin
        // A killed read must drain before the next request goes out.
        if (r_kill) begin
          if (imem_rvalid) w_kill_nxt = 1'b0;
        end else begin
          w_state_nxt = c_WAIT;
        end
      end
      c_WAIT: begin
        if (imem_rvalid) w_state_nxt = c_VALID;
      end
      c_VALID: begin
        if (id_ready) w_state_nxt = c_REQ;
      end
      default: w_state_nxt = c_IDLE;
    endcase
    if (w_flush) begin
      w_state_nxt = c_REQ;
      // Kill only if a read is still outstanding after this cycle.
      w_kill_nxt  = imem_req || (((r_state == c_WAIT) || r_kill) && !imem_rvalid);
    end
    if (w_trap) w_state_nxt = c_IDLE;
  end

  always_comb begin
    imem_req  = (r_state == c_REQ) && !r_kill;
    imem_addr = r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_pc_out      <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_flush || w_consume) begin
      r_pc          <= w_next_pc;
      r_instr_valid <= 1'b0;
    end else if (w_accept) begin
      r_instr       <= imem_rdata;
      r_pc_out      <= r_pc;
      r_pc          <= r_pc + c_STEP;
      r_instr_valid <= 1'b1;
    end
  end

  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_instr_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus for fetch_unit, checked every cycle against a
// transaction-level model (pending-request / in-flight / stale-read bookkeeping) plus literal expectations.
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        id_ready;
  logic [1:0]  PCSrc;
  logic [31:0] ImmOp;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misalign;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int lat_force = 1;
  bit spur_en   = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(c_RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
    .id_ready(id_ready), .PCSrc(PCSrc), .ImmOp(ImmOp),
    .flush(flush), .flush_pc(flush_pc), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  // Memory: one response per request after lat cycles, optional stray strobes while idle.
  int          mem_lat;
  bit          mem_busy;
  logic [31:0] mem_addr;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    mem_busy    = 1'b0;
    mem_lat     = 0;
    mem_addr    = '0;
    forever begin
      bit was_busy;
      @(posedge clk); #1;
      was_busy    = mem_busy;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_busy) begin
        mem_lat--;
        if (mem_lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_busy    = 1'b0;
        end
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        imem_rvalid = 1'b1;
      end
      if (imem_req) begin
        chk("single_outstanding", 32'(was_busy), 32'd0);
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_lat  = (lat_force != 0) ? lat_force : $urandom_range(1, 3);
      end
    end
  end

  // Reference model: fetch is "wanted" after boot/consume/flush; a request goes out when
  // wanted and nothing is in flight; a flushed in-flight read becomes stale and is discarded.
  bit          m_boot, m_want, m_inflight, m_stale, m_valid, m_mis, m_parked;
  logic [31:0] m_pc, m_instr, m_pcout;

  task automatic m_reset();
    m_boot = 1; m_want = 0; m_inflight = 0; m_stale = 0; m_valid = 0;
    m_mis = 0; m_parked = 0; m_pc = c_RESET_PC; m_instr = '0; m_pcout = '0;
  endtask

  task automatic m_redirect(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    m_pc = t;
    if (t[1:0] != 2'b00) begin
      m_mis = 1; m_parked = 1; m_want = 0;
    end
`else
    m_pc = t & 32'hFFFF_FFFC;
`endif
  endtask

  initial begin
    m_reset();
    forever begin
      bit exp_req, resp, fresh;
      @(negedge clk);
      cyc++;
      if (!rst_n) m_reset();
      exp_req = !m_boot && m_want && !m_inflight && !m_parked;
      chk("imem_req",    32'(imem_req),    32'(exp_req));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr",       instr,            m_instr);
      chk("pc_out",      pc_out,           m_pcout);
      chk("misalign",    32'(misalign),    32'(m_mis));
      if (rst_n) begin
        if (m_boot) begin
          m_boot = 0;
          m_want = 1;
        end else if (!m_parked) begin
          resp  = imem_rvalid && m_inflight;
          fresh = resp && !m_stale;
          if (resp) begin m_inflight = 0; m_stale = 0; end
          if (exp_req) begin m_inflight = 1; m_want = 0; end
          if (flush) begin
            m_valid = 0; m_want = 1;
            if (m_inflight) m_stale = 1;
            m_redirect(flush_pc);
          end else if (fresh) begin
            m_valid = 1; m_instr = imem_rdata; m_pcout = m_pc; m_pc = m_pc + 32'd4;
          end else if (m_valid && id_ready) begin
            m_valid = 0; m_want = 1;
            case (PCSrc)
              2'b01:   m_redirect(m_pcout + ImmOp);
              2'b10:   m_redirect(ImmOp);
              default: m_pc = m_pc;
            endcase
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(output logic [31:0] a, output int c, output bit ok);
    ok = 0; a = '0; c = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req) begin a = imem_addr; c = cyc; ok = 1; break; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instr_valid) begin ok = 1; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, saved;
    int          c, c_prev;
    bit          ok;
    rst_n = 1'b1; flush = 0; flush_pc = '0; id_ready = 0; PCSrc = 2'b00; ImmOp = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, c_RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // Sequential fetch with 1-cycle memory and decode always ready.
    rst_n = 1'b1; id_ready = 1;
    c_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_req(a, c, ok);
      chk("seq_req_seen", 32'(ok), 32'd1);
      chk("seq_addr", a, 32'(k * 4));
      if (k > 0) chk("seq_gap", 32'(c - c_prev), 32'd3);
      c_prev = c;
    end

    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instr_valid && pc_out == 32'h10) begin
        chk("instr_at_10", instr, mem_word(32'h10));
        PCSrc = 2'b01; ImmOp = 32'hFFFF_FFF8; ok = 1;
        break;
      end
    end
    chk("reach_10", 32'(ok), 32'd1);
    tick();
    PCSrc = 2'b00;
    chk("rel_branch_req", 32'(imem_req), 32'd1);
    chk("rel_branch_addr", imem_addr, 32'h8);

    wait_valid(ok);
    chk("valid_at_8", pc_out, 32'h8);
    PCSrc = 2'b10; ImmOp = 32'h200;
    tick();
    PCSrc = 2'b00;
    chk("jump_addr", imem_addr, 32'h200);
    chk("jump_req", 32'(imem_req), 32'd1);

    // Decode stall for 5 cycles.
    id_ready = 0;
    wait_valid(ok);
    chk("stall_valid", 32'(ok), 32'd1);
    chk("stall_pc", pc_out, 32'h200);
    saved = instr;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_noreq", 32'(imem_req), 32'd0);
      chk("stall_instr", instr, saved);
      chk("stall_pc_hold", pc_out, 32'h200);
    end
    tick();
    id_ready = 1; lat_force = 3;
    tick();
    chk("after_stall_req", 32'(imem_req), 32'd1);
    chk("after_stall_addr", imem_addr, 32'h204);

    // Flush in WAIT; stale response three cycles after the request.
    tick();
    flush = 1; flush_pc = 32'h400;
    tick();
    flush = 0;
    chk("kill_noreq1", 32'(imem_req), 32'd0);
    tick();
    chk("kill_noreq2", 32'(imem_req), 32'd0);
    chk("kill_novalid", 32'(instr_valid), 32'd0);
    lat_force = 2;
    tick();
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", imem_addr, 32'h400);

    // Reset during WAIT; response lands while reset is asserted.
    tick();
    rst_n = 0;
    #1;
    chk("async_rst_addr", imem_addr, c_RESET_PC);
    chk("async_rst_pc_out", pc_out, 32'd0);
    repeat (4) tick();
    rst_n = 1; lat_force = 1;
    wait_req(a, c, ok);
    chk("post_rst_req", 32'(ok), 32'd1);
    chk("post_rst_addr", a, c_RESET_PC);

    // Randomized traffic.
    lat_force = 0; spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      id_ready = ($urandom_range(0, 9) < 6);
      PCSrc    = 2'($urandom_range(0, 3));
      ImmOp    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF80 + (32'($urandom_range(0, 63)) << 2))
                                             : (32'($urandom) & 32'h000F_FFFC);
      flush    = ($urandom_range(0, 15) == 0);
      flush_pc = 32'($urandom) & 32'h000F_FFFC;
`ifndef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 9) == 0) ImmOp[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) flush_pc[1:0] = 2'($urandom_range(1, 3));
`endif
    end

    // Misaligned jump target 0x102.
    flush = 0; id_ready = 0; PCSrc = 2'b00;
    wait_valid(ok);
    chk("mis_valid_seen", 32'(ok), 32'd1);
    PCSrc = 2'b10; ImmOp = 32'h102; id_ready = 1;
    tick();
    PCSrc = 2'b00; id_ready = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("mis_parked_noreq", 32'(imem_req), 32'd0);
      chk("mis_parked_novalid", 32'(instr_valid), 32'd0);
      tick();
    end
`else
    chk("mis_req", 32'(imem_req), 32'd1);
    chk("mis_aligned_addr", imem_addr, 32'h100);
    chk("mis_flag_zero", 32'(misalign), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
